// File: rtl/subservient_wb_copier_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : subservient_wb_copier_if
// Brief    : Read-port and write-port Wishbone signals of the boot copier.
// Revision : 1.0 - initial release
// ============================================================================
interface subservient_wb_copier_if;
    logic [31:0] wb_rd_adr_o;
    logic        wb_rd_stb_o;
    logic [31:0] wb_rd_dat_i;
    logic        wb_rd_ack_i;
    logic [31:0] wb_wr_adr_o;
    logic [31:0] wb_wr_dat_o;
    logic [3:0]  wb_wr_sel_o;
    logic        wb_wr_we_o;
    logic        wb_wr_stb_o;
    logic        wb_wr_ack_i;

    modport master (
        output wb_rd_adr_o, wb_rd_stb_o,
        input  wb_rd_dat_i, wb_rd_ack_i,
        output wb_wr_adr_o, wb_wr_dat_o, wb_wr_sel_o, wb_wr_we_o, wb_wr_stb_o,
        input  wb_wr_ack_i
    );

    modport slave (
        input  wb_rd_adr_o, wb_rd_stb_o,
        output wb_rd_dat_i, wb_rd_ack_i,
        input  wb_wr_adr_o, wb_wr_dat_o, wb_wr_sel_o, wb_wr_we_o, wb_wr_stb_o,
        output wb_wr_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/subservient_wb_copier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : subservient_wb_copier
// Brief    : Copies LENGTH bytes from boot ROM to RAM, then releases CPU reset.
// Revision : 1.0 - initial release
// ============================================================================
module subservient_wb_copier #(
    parameter int unsigned LENGTH   = 0,
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0000_0000
) (
    input  wire logic                      wb_clk_i,
    input  wire logic                      wb_rst_i,
    subservient_wb_copier_if.master        bus,
    output logic                           done_o,
    output logic                           cpu_rst_o
);

    localparam int unsigned WORDS = LENGTH / 4;
    localparam int unsigned IDXW  = $clog2(WORDS) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic [IDXW-1:0] idx_inc;

    assign idx_inc = idx_q + IDXW'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Acks are only honoured in the state whose strobe is high.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (WORDS != 0) state_d = S_READ;
                else            state_d = S_DONE;
            end
            S_READ: begin
                if (bus.wb_rd_ack_i) begin
                    data_d  = bus.wb_rd_dat_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.wb_wr_ack_i) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == LAST_IDX) ? S_DONE : S_READ;
                end
            end
            default: state_d = S_DONE;
        endcase
    end

    assign bus.wb_rd_stb_o = (state_q == S_READ);
    assign bus.wb_wr_stb_o = (state_q == S_WRITE);
    assign bus.wb_rd_adr_o = SRC_BASE + (32'(idx_q) << 2);
    assign bus.wb_wr_adr_o = DST_BASE + (32'(idx_q) << 2);
    assign bus.wb_wr_dat_o = data_q;
    assign bus.wb_wr_sel_o = 4'hF;
    assign bus.wb_wr_we_o  = 1'b1;
    assign done_o          = (state_q == S_DONE);
    assign cpu_rst_o       = (state_q != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_subservient_wb_copier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_subservient_wb_copier
// Brief    : Randomized ROM/RAM responders and a block-copy reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subservient_wb_copier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subservient_wb_copier_if ifa ();
    subservient_wb_copier_if ifb ();
    subservient_wb_copier_if ifc ();

    logic done_a, done_b, done_c, cpurst_a, cpurst_b, cpurst_c;

    subservient_wb_copier #(.LENGTH(16), .SRC_BASE(32'h0000_0000), .DST_BASE(32'h0000_0100)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa.master), .done_o(done_a), .cpu_rst_o(cpurst_a));
    subservient_wb_copier #(.LENGTH(0), .SRC_BASE(32'h0000_0000), .DST_BASE(32'h0000_0000)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb.master), .done_o(done_b), .cpu_rst_o(cpurst_b));
    subservient_wb_copier #(.LENGTH(8), .SRC_BASE(32'hFFFF_FFFC), .DST_BASE(32'h0000_0200)) u_dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifc.master), .done_o(done_c), .cpu_rst_o(cpurst_c));

    // Index 0 is the 4-word copier, index 1 the 2-word wrapping copier.
    logic        o_rd_stb [2];
    logic        o_wr_stb [2];
    logic [31:0] o_rd_adr [2];
    logic [31:0] o_wr_adr [2];
    logic [31:0] o_wr_dat [2];
    logic [31:0] rd_dat   [2];
    logic        rd_ack   [2];
    logic        wr_ack   [2];

    assign o_rd_stb[0] = ifa.wb_rd_stb_o;  assign o_rd_stb[1] = ifc.wb_rd_stb_o;
    assign o_wr_stb[0] = ifa.wb_wr_stb_o;  assign o_wr_stb[1] = ifc.wb_wr_stb_o;
    assign o_rd_adr[0] = ifa.wb_rd_adr_o;  assign o_rd_adr[1] = ifc.wb_rd_adr_o;
    assign o_wr_adr[0] = ifa.wb_wr_adr_o;  assign o_wr_adr[1] = ifc.wb_wr_adr_o;
    assign o_wr_dat[0] = ifa.wb_wr_dat_o;  assign o_wr_dat[1] = ifc.wb_wr_dat_o;
    assign ifa.wb_rd_dat_i = rd_dat[0];    assign ifc.wb_rd_dat_i = rd_dat[1];
    assign ifa.wb_rd_ack_i = rd_ack[0];    assign ifc.wb_rd_ack_i = rd_ack[1];
    assign ifa.wb_wr_ack_i = wr_ack[0];    assign ifc.wb_wr_ack_i = wr_ack[1];
    assign ifb.wb_rd_dat_i = 32'h0;
    assign ifb.wb_rd_ack_i = 1'b0;
    assign ifb.wb_wr_ack_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int waits_en = 0;
    int spur_en  = 0;
    int rd_cnt [2];
    int wr_cnt [2];
    logic [31:0] wl_adr [2][8];
    logic [31:0] wl_dat [2][8];
    logic [31:0] rl_adr [2][8];
    int wl_n [2];
    int rl_n [2];
    int unstable = 0, overlap = 0, b_stb_seen = 0, cpurst_bad = 0;
    int da, db, dc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a < 32'd16) return ((a >> 2) + 32'd1) * 32'h1111_1111;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int reload();
        return (waits_en != 0) ? 2 + int'($urandom_range(0, 5)) : 2;
    endfunction

    // Responders: registered ack two negedges after strobe seen, plus wait states.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_ack[k]) begin
                rd_ack[k] = 1'b0;
                rd_cnt[k] = reload();
                rd_dat[k] = $urandom;
            end else if (o_rd_stb[k]) begin
                if (rd_cnt[k] > 1) rd_cnt[k]--;
                else begin
                    rd_ack[k] = 1'b1;
                    rd_dat[k] = rom(o_rd_adr[k]);
                    if (rl_n[k] < 8) rl_adr[k][rl_n[k]] = o_rd_adr[k];
                    rl_n[k]++;
                end
            end else begin
                rd_cnt[k] = reload();
                if (spur_en != 0 && $urandom_range(0, 2) == 0) begin
                    rd_ack[k] = 1'b1;
                    rd_dat[k] = $urandom;
                end
            end
            if (wr_ack[k]) begin
                wr_ack[k] = 1'b0;
                wr_cnt[k] = reload();
            end else if (o_wr_stb[k]) begin
                if (wr_cnt[k] > 1) wr_cnt[k]--;
                else begin
                    wr_ack[k] = 1'b1;
                    if (wl_n[k] < 8) begin
                        wl_adr[k][wl_n[k]] = o_wr_adr[k];
                        wl_dat[k][wl_n[k]] = o_wr_dat[k];
                    end
                    wl_n[k]++;
                end
            end else begin
                wr_cnt[k] = reload();
                if (spur_en != 0 && $urandom_range(0, 2) == 0) wr_ack[k] = 1'b1;
            end
        end
    end

    logic        prv_rd_stb [2] = '{1'b0, 1'b0};
    logic        prv_wr_stb [2] = '{1'b0, 1'b0};
    logic [31:0] prv_rd_adr [2];
    logic [31:0] prv_wr_adr [2];
    logic [31:0] prv_wr_dat [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_rd_stb[k] && o_wr_stb[k]) overlap++;
            if (prv_rd_stb[k] && o_rd_stb[k] && (o_rd_adr[k] != prv_rd_adr[k])) unstable++;
            if (prv_wr_stb[k] && o_wr_stb[k] &&
                ((o_wr_adr[k] != prv_wr_adr[k]) || (o_wr_dat[k] != prv_wr_dat[k]))) unstable++;
            prv_rd_stb[k] = o_rd_stb[k];
            prv_wr_stb[k] = o_wr_stb[k];
            prv_rd_adr[k] = o_rd_adr[k];
            prv_wr_adr[k] = o_wr_adr[k];
            prv_wr_dat[k] = o_wr_dat[k];
        end
        if (ifb.wb_rd_stb_o || ifb.wb_wr_stb_o) b_stb_seen++;
    end

    // Releases reset on the current negedge and counts rising edges until done.
    task automatic run(input int budget);
        int cyc;
        for (int k = 0; k < 2; k++) begin
            wl_n[k] = 0;
            rl_n[k] = 0;
        end
        da = -1; db = -1; dc = -1; cyc = 0;
        rst = 1'b0;
        while (cyc < budget && (da < 0 || dc < 0 || db < 0)) begin
            @(posedge clk); #1;
            cyc++;
            if (done_a && da < 0) da = cyc;
            if (done_b && db < 0) db = cyc;
            if (done_c && dc < 0) dc = cyc;
            if (cpurst_a === done_a || cpurst_b === done_b || cpurst_c === done_c) cpurst_bad++;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ram(input string sc);
        int nexp;
        logic [31:0] ea, ed;
        for (int k = 0; k < 2; k++) begin
            nexp = (k == 0) ? 4 : 2;
            chk({sc, "_nwrites"}, 32'(wl_n[k]), 32'(nexp));
            for (int i = 0; i < nexp && i < wl_n[k]; i++) begin
                ea = ((k == 0) ? 32'h100 : 32'h200) + 32'(4 * i);
                ed = rom(((k == 0) ? 32'h0 : 32'hFFFF_FFFC) + 32'(4 * i));
                chk({sc, "_wadr"}, wl_adr[k][i], ea);
                chk({sc, "_wdat"}, wl_dat[k][i], ed);
            end
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd_ack[k] = 1'b0; wr_ack[k] = 1'b0; rd_dat[k] = 32'h0;
            rd_cnt[k] = 2; wr_cnt[k] = 2; wl_n[k] = 0; rl_n[k] = 0;
        end
        repeat (3) @(posedge clk); #1;
        chk("rst_rd_stb", 32'(ifa.wb_rd_stb_o), 32'd0);
        chk("rst_wr_stb", 32'(ifa.wb_wr_stb_o), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_cpu_rst", 32'(cpurst_a), 32'd1);
        chk("rst_rd_adr", ifa.wb_rd_adr_o, 32'h0);
        chk("rst_wr_adr", ifa.wb_wr_adr_o, 32'h100);
        chk("rst_wr_dat", ifa.wb_wr_dat_o, 32'h0);
        chk("rst_sel", 32'(ifa.wb_wr_sel_o), 32'hF);
        chk("rst_we", 32'(ifa.wb_wr_we_o), 32'd1);
        chk("rst_c_rd_adr", ifc.wb_rd_adr_o, 32'hFFFF_FFFC);
        @(negedge clk);

        run(400);
        chk("s1_done_cycle_a", 32'(da), 32'd17);
        chk("s1_done_cycle_len0", 32'(db), 32'd1);
        chk("s1_done_cycle_c", 32'(dc), 32'd9);
        chk("s1_cpu_rst", 32'(cpurst_a), 32'd0);
        check_ram("s1");
        chk("s1_wrap_rd0", rl_adr[1][0], 32'hFFFF_FFFC);
        chk("s1_wrap_rd1", rl_adr[1][1], 32'h0000_0000);

        reset_dut();
        waits_en = 1;
        run(2000);
        chk("s2_done_seen", 32'(da > 0 && dc > 0), 32'd1);
        check_ram("s2");

        reset_dut();
        spur_en = 1;
        run(2000);
        repeat (20) @(posedge clk);
        #1;
        chk("s3_done_sticky", 32'(done_a), 32'd1);
        check_ram("s3");
        spur_en = 0;
        waits_en = 0;

        reset_dut();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (o_wr_stb[0] && o_wr_adr[0] == 32'h108) found = 1'b1;
        end
        chk("s4_reach_word2", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("s4_rd_stb", 32'(ifa.wb_rd_stb_o), 32'd0);
        chk("s4_wr_stb", 32'(ifa.wb_wr_stb_o), 32'd0);
        chk("s4_done", 32'(done_a), 32'd0);
        chk("s4_cpu_rst", 32'(cpurst_a), 32'd1);
        @(negedge clk);
        run(400);
        chk("s4_done_cycle", 32'(da), 32'd17);
        check_ram("s4");

        chk("strobe_overlap", 32'(overlap), 32'd0);
        chk("strobe_stability", 32'(unstable), 32'd0);
        chk("len0_no_strobe", 32'(b_stb_seen), 32'd0);
        chk("cpu_rst_vs_done", 32'(cpurst_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subservient_wb_copier.md
# subservient_wb_copier

Wishbone initiator that copies a fixed-size block of 32-bit words from a read-only Wishbone responder (boot ROM) into a writable Wishbone responder (RAM) after reset. It then asserts a sticky done flag and releases the CPU reset. It sits between the boot ROM and the data RAM arbiter, and holds the core in reset until the image is in place.

## Interface
Parameters:
- LENGTH, 0: bytes to copy; multiple of 4; 0 = nothing to copy.
- SRC_BASE, 32'h0000_0000: byte address of first source word.
- DST_BASE, 32'h0000_0000: byte address of first destination word.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_rd_adr_o  out  32  source byte address.
- wb_rd_stb_o  out  1  source request (cyc = stb).
- wb_rd_dat_i  in  32  source read data; valid with ack.
- wb_rd_ack_i  in  1  source acknowledge.
- wb_wr_adr_o  out  32  destination byte address.
- wb_wr_dat_o  out  32  destination write data.
- wb_wr_sel_o  out  4  byte enables; always 4'hF.
- wb_wr_we_o  out  1  write enable; always 1.
- wb_wr_stb_o  out  1  destination request (cyc = stb).
- wb_wr_ack_i  in  1  destination acknowledge.
- done_o  out  1  copy complete; sticky until reset.
- cpu_rst_o  out  1  CPU reset; equals !done_o.

## Operation
- Word counter idx, width $clog2(LENGTH/4)+1. The counter counts 0..LENGTH/4.
- wb_rd_adr_o = SRC_BASE + 4*idx. wb_wr_adr_o = DST_BASE + 4*idx. Both are 32-bit and wrap modulo 2^32. Both are low 2 bits zero if the bases are aligned.
- The FSM is registered. All strobes and done_o are decoded from state only, so they are glitch-free and never depend combinationally on inputs.
  - IDLE: entered on reset. Next cycle goes to READ if LENGTH>0, else to DONE.
  - READ: wb_rd_stb_o=1 and the address is held. On wb_rd_ack_i: capture wb_rd_dat_i into the data register, go to WRITE.
  - WRITE: wb_wr_stb_o=1. Address and data are held. On wb_wr_ack_i: idx <= idx+1. Go to DONE if idx+1 == LENGTH/4, else to READ.
  - DONE: terminal. done_o=1, cpu_rst_o=0, both strobes 0.
- At most one strobe is high in any cycle. Read and write are never overlapped.
- An ack on a port whose strobe is low is ignored and causes no state, data or counter change.
- wb_wr_dat_o always presents the data register. The data register is only meaningful while wb_wr_stb_o=1.
- Reset in any state, including mid-transfer: strobes drop the next cycle, idx=0, state=IDLE, done_o=0, cpu_rst_o=1. The copy restarts from word 0.

## Timing
- Reset values: wb_rd_stb_o=0, wb_wr_stb_o=0, done_o=0, cpu_rst_o=1, idx=0, data register=0.
- Addresses at reset: SRC_BASE and DST_BASE. wb_wr_sel_o=4'hF and wb_wr_we_o=1 at all times.
- A strobe stays high until the cycle its ack is sampled. It is low the following cycle.
- Responders with 1-cycle registered ack (ack = stb & !ack) take 2 cycles per phase, so 4 cycles per word. No back-to-back duplicate ack is consumed.
- With 1-cycle acks, done_o rises exactly 1 + 4*(LENGTH/4) cycles after the first cycle with wb_rst_i low. It is 1 cycle for LENGTH=0.
- Each wait state on either port adds exactly one cycle to that phase.

## Test plan
- LENGTH=16, SRC_BASE=0, DST_BASE=32'h100, ROM model holding 11111111/22222222/33333333/44444444, 1-cycle acks:
  - required writes: 0x100=11111111, 0x104=22222222, 0x108=33333333, 0x10C=44444444, in that order;
  - done_o rises on cycle 17 after reset release; cpu_rst_o falls the same cycle.
- Same setup with random 0-5 wait states on each ack:
  - RAM contents are identical to the first scenario;
  - wb_rd_adr_o, wb_wr_adr_o and wb_wr_dat_o stay stable while their strobe is high;
  - rd and wr strobes are never high together.
- LENGTH=0: no strobe is ever asserted; done_o=1 on cycle 1 after reset release.
- Spurious wb_rd_ack_i and wb_wr_ack_i pulses while the matching strobe is low: no extra writes, idx is unchanged, final RAM is correct.
- Assert wb_rst_i during the WRITE of word 2 of 4:
  - strobes are 0 the next cycle; done_o=0;
  - after release, all 4 words are rewritten starting from address DST_BASE, and done_o rises at cycle 17.
- LENGTH=8 with SRC_BASE=32'hFFFF_FFFC: the second read address wraps to 32'h0000_0000.
